// File: rtl/reconfig_cpu_debug_pkg.sv
// Shared types and jdo field layout for the debug on-chip memory (OCI RAM) block.
package reconfig_cpu_debug_pkg;

    localparam int JDO_W        = 38;
    localparam int JDO_RD_BIT   = 35;
    localparam int JDO_ADDR_LSB = 26;
    localparam int JDO_DATA_LSB = 3;
    localparam int MON_DATA_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_JRD  = 2'd1,
        ST_JCAP = 2'd2,
        ST_JWR  = 2'd3
    } ocimem_state_e;

endpackage

// File: rtl/reconfig_cpu_debug_ocimem_ram.sv
// Single-port synchronous RAM, one-cycle registered read, no reset on contents.
module reconfig_cpu_debug_ocimem_ram #(
    parameter int AW     = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic [AW-1:0]     addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        q <= mem[addr];
    end

endmodule

// File: rtl/reconfig_cpu_debug_ocimem.sv
// Debug on-chip memory: JTAG monitor access (MonAReg/MonDReg) sharing one RAM with the CPU port.
// Build option: RECONFIG_CPU_OCIMEM_WRITE_PROTECT_EN suppresses writes at or above RO_BASE.
module reconfig_cpu_debug_ocimem
    import reconfig_cpu_debug_pkg::*;
#(
    parameter int          AW      = 8,
    parameter int unsigned RO_BASE = 8'hC0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [JDO_W-1:0]      jdo,
    input  logic                  take_action_ocimem_a,
    input  logic                  take_action_ocimem_b,
    input  logic                  take_no_action_ocimem_a,
    input  logic [AW-1:0]         address,
    input  logic                  read,
    input  logic                  write,
    input  logic [MON_DATA_W-1:0] writedata,
    output logic [MON_DATA_W-1:0] readdata,
    output logic                  waitrequest,
    output logic [MON_DATA_W-1:0] MonDReg,
    output logic                  monitor_ready,
    output logic                  monitor_error
);

    ocimem_state_e         state;
    logic [AW-1:0]         MonAReg;
    logic                  rd_inc;
    logic [MON_DATA_W-1:0] wr_data_p1;
    logic                  cpu_rd_vld_p1;
    logic [MON_DATA_W-1:0] readdata_p1;

    logic                  any_take;
    logic                  multi_take;
    logic                  fsm_idle;
    logic                  cpu_wr_acc;
    logic                  cpu_rd_acc;
    logic                  jtag_mem;
    logic                  jtag_wr_ok;
    logic                  cpu_wr_ok;
    logic [AW-1:0]         ram_addr;
    logic                  ram_we;
    logic [MON_DATA_W-1:0] ram_wdata;
    logic [MON_DATA_W-1:0] ram_q;
    logic                  unused_jdo;

    assign unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_DATA_LSB-1:0]};

    assign any_take   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign multi_take = (take_action_ocimem_a & take_action_ocimem_b)
                      | (take_action_ocimem_a & take_no_action_ocimem_a)
                      | (take_action_ocimem_b & take_no_action_ocimem_a);
    assign fsm_idle   = (state == ST_IDLE);

    // A strobe stalls the CPU in its own cycle so the JTAG op never races a CPU access.
    assign waitrequest = !fsm_idle || any_take;
    assign cpu_wr_acc  = write && !waitrequest;
    assign cpu_rd_acc  = read && !write && !waitrequest;
    assign jtag_mem    = (state == ST_JRD) || (state == ST_JWR);

`ifdef RECONFIG_CPU_OCIMEM_WRITE_PROTECT_EN
    assign jtag_wr_ok = (32'(MonAReg) < RO_BASE);
    assign cpu_wr_ok  = (32'(address) < RO_BASE);
`else
    logic unused_ro_base;
    assign unused_ro_base = ^RO_BASE;
    assign jtag_wr_ok     = 1'b1;
    assign cpu_wr_ok      = 1'b1;
`endif

    assign ram_addr  = jtag_mem ? MonAReg : address;
    assign ram_we    = ((state == ST_JWR) && jtag_wr_ok) || (cpu_wr_acc && cpu_wr_ok);
    assign ram_wdata = (state == ST_JWR) ? wr_data_p1 : writedata;

    reconfig_cpu_debug_ocimem_ram #(
        .AW     (AW),
        .DATA_W (MON_DATA_W)
    ) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .q     (ram_q)
    );

    // Stage p1: CPU read data returns straight from the RAM register, then is held.
    assign readdata = cpu_rd_vld_p1 ? ram_q : readdata_p1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rd_vld_p1 <= 1'b0;
            readdata_p1   <= '0;
        end else begin
            cpu_rd_vld_p1 <= cpu_rd_acc;
            if (cpu_rd_vld_p1) begin
                readdata_p1 <= ram_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fsm_idle && take_action_ocimem_b) begin
            wr_data_p1 <= jdo[JDO_DATA_LSB +: MON_DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            rd_inc        <= 1'b0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (take_action_ocimem_a) begin
                        MonAReg       <= jdo[JDO_ADDR_LSB +: AW];
                        monitor_ready <= 1'b0;
                        monitor_error <= multi_take;
                        rd_inc        <= 1'b0;
                        state         <= jdo[JDO_RD_BIT] ? ST_JRD : ST_IDLE;
                    end else if (take_action_ocimem_b) begin
                        monitor_ready <= 1'b0;
                        state         <= ST_JWR;
                        if (multi_take) monitor_error <= 1'b1;
                    end else if (take_no_action_ocimem_a) begin
                        monitor_ready <= 1'b0;
                        rd_inc        <= 1'b1;
                        state         <= ST_JRD;
                    end
                end
                ST_JRD: begin
                    state <= ST_JCAP;
                    if (any_take) monitor_error <= 1'b1;
                end
                ST_JCAP: begin
                    MonDReg       <= ram_q;
                    monitor_ready <= 1'b1;
                    if (rd_inc) MonAReg <= MonAReg + AW'(1);
                    if (any_take) monitor_error <= 1'b1;
                    state         <= ST_IDLE;
                end
                ST_JWR: begin
                    // The address still advances when a protected write is suppressed.
                    MonAReg       <= MonAReg + AW'(1);
                    monitor_ready <= 1'b1;
                    if (any_take || !jtag_wr_ok) monitor_error <= 1'b1;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_reconfig_cpu_debug_ocimem.sv
// Directed scoreboard bench for reconfig_cpu_debug_ocimem (JTAG monitor path and CPU port).
module tb_reconfig_cpu_debug_ocimem;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_a;
    logic        take_b;
    logic        take_na;
    logic [7:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] mon_exp_q[$];
    logic [31:0] cpu_exp_q[$];

    reconfig_cpu_debug_ocimem #(
        .AW      (8),
        .RO_BASE (8'hC0)
    ) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_a),
        .take_action_ocimem_b    (take_b),
        .take_no_action_ocimem_a (take_na),
        .address                 (address),
        .read                    (read),
        .write                   (write),
        .writedata               (writedata),
        .readdata                (readdata),
        .waitrequest             (waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of sequence");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_mon(input string tag);
        logic [31:0] e;
        check({tag, "_sb"}, 32'(mon_exp_q.size()), 32'd1);
        if (mon_exp_q.size() != 0) begin
            e = mon_exp_q.pop_front();
            check(tag, MonDReg, e);
        end
    endtask

    task automatic pop_cpu(input string tag);
        logic [31:0] e;
        check({tag, "_sb"}, 32'(cpu_exp_q.size()), 32'd1);
        if (cpu_exp_q.size() != 0) begin
            e = cpu_exp_q.pop_front();
            check(tag, readdata, e);
        end
    endtask

    task automatic wait_ready(input string tag, input int n0, input int exp_n);
        int n = n0;
        while (monitor_ready !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
    endtask

    task automatic jtag_a(input logic [7:0] a, input logic rd);
        jdo = '0;
        jdo[33:26] = a;
        jdo[35] = rd;
        take_a = 1'b1;
        @(negedge clk);
        take_a = 1'b0;
    endtask

    task automatic jtag_b(input logic [31:0] d);
        jdo = '0;
        jdo[34:3] = d;
        take_b = 1'b1;
        @(negedge clk);
        take_b = 1'b0;
    endtask

    task automatic jtag_na();
        take_na = 1'b1;
        @(negedge clk);
        take_na = 1'b0;
    endtask

    task automatic cpu_write(input string tag, input logic [7:0] a, input logic [31:0] d);
        int n = 0;
        address = a;
        writedata = d;
        write = 1'b1;
        #1;
        while (waitrequest === 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_wait"}, 32'(n), 32'd0);
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic cpu_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
        int n = 0;
        cpu_exp_q.push_back(exp);
        address = a;
        read = 1'b1;
        #1;
        while (waitrequest === 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_wait"}, 32'(n), 32'd0);
        @(negedge clk);
        read = 1'b0;
        #1;
        pop_cpu(tag);
    endtask

    initial begin
        int n;
        reset_n = 1'b0;
        jdo = '0;
        take_a = 1'b0;
        take_b = 1'b0;
        take_na = 1'b0;
        address = '0;
        read = 1'b0;
        write = 1'b0;
        writedata = '0;
        repeat (3) @(negedge clk);

        check("rst_mondreg", MonDReg, 32'd0);
        check("rst_ready", 32'(monitor_ready), 32'd0);
        check("rst_error", 32'(monitor_error), 32'd0);
        check("rst_readdata", readdata, 32'd0);
        check("rst_waitreq", 32'(waitrequest), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        cpu_write("pre_w20", 8'h20, 32'h12345678);
        cpu_write("pre_w40", 8'h40, 32'h40404040);
`ifndef RECONFIG_CPU_OCIMEM_WRITE_PROTECT_EN
        cpu_write("pre_wff", 8'hFF, 32'hA5A50FF0);
`endif

        // JTAG address load, then two writes through the auto-incrementing address.
        jtag_a(8'h10, 1'b0);
        check("a_nord_ready", 32'(monitor_ready), 32'd0);
        jtag_b(32'hDEADBEEF);
        wait_ready("b1", 1, 2);
        jtag_b(32'hCAFEF00D);
        wait_ready("b2", 1, 2);
        check("b_error", 32'(monitor_error), 32'd0);
        cpu_read("cpu_r10", 8'h10, 32'hDEADBEEF);
        cpu_read("cpu_r11", 8'h11, 32'hCAFEF00D);

        // JTAG read with exact latency.
        mon_exp_q.push_back(32'hDEADBEEF);
        jtag_a(8'h10, 1'b1);
        check("rd_early_ready", 32'(monitor_ready), 32'd0);
        wait_ready("rd10", 1, 3);
        pop_mon("rd10_mon");

        // CPU read held across a JTAG read.
        mon_exp_q.push_back(32'h12345678);
        cpu_exp_q.push_back(32'hDEADBEEF);
        jdo = '0;
        jdo[33:26] = 8'h20;
        jdo[35] = 1'b1;
        take_a = 1'b1;
        address = 8'h10;
        read = 1'b1;
        n = 0;
        #1;
        while (waitrequest === 1'b1 && n < 20) begin
            @(negedge clk);
            take_a = 1'b0;
            #1;
            n++;
        end
        take_a = 1'b0;
        check("stall_cycles", 32'(n), 32'd3);
        check("stall_ready", 32'(monitor_ready), 32'd1);
        pop_mon("stall_mon");
        @(negedge clk);
        read = 1'b0;
        #1;
        pop_cpu("stall_rd");

        // Streaming read at the top address wraps MonAReg to zero.
`ifndef RECONFIG_CPU_OCIMEM_WRITE_PROTECT_EN
        mon_exp_q.push_back(32'hA5A50FF0);
`endif
        jtag_a(8'hFF, 1'b0);
        jtag_na();
        wait_ready("wrap_rd", 1, 3);
`ifndef RECONFIG_CPU_OCIMEM_WRITE_PROTECT_EN
        pop_mon("wrap_mon");
`endif
        check("wrap_error", 32'(monitor_error), 32'd0);
        jtag_b(32'h0BADF00D);
        wait_ready("wrap_b", 1, 2);
        cpu_read("wrap_r00", 8'h00, 32'h0BADF00D);

        // Write strobe while busy with a read is dropped.
        mon_exp_q.push_back(32'hDEADBEEF);
        jtag_a(8'h10, 1'b1);
        jdo = '0;
        jdo[34:3] = 32'h11111111;
        take_b = 1'b1;
        @(negedge clk);
        take_b = 1'b0;
        wait_ready("drop", 2, 3);
        pop_mon("drop_mon");
        check("drop_error", 32'(monitor_error), 32'd1);
        cpu_read("drop_r10", 8'h10, 32'hDEADBEEF);
        mon_exp_q.push_back(32'hDEADBEEF);
        jtag_na();
        wait_ready("drop_na", 1, 3);
        pop_mon("drop_na_mon");
        check("drop_sticky", 32'(monitor_error), 32'd1);

        // Simultaneous a and b: only a runs, error flagged.
        jtag_a(8'h30, 1'b0);
        check("a_clr_error", 32'(monitor_error), 32'd0);
        mon_exp_q.push_back(32'h12345678);
        jdo = '0;
        jdo[33:26] = 8'h20;
        jdo[35] = 1'b1;
        take_a = 1'b1;
        take_b = 1'b1;
        @(negedge clk);
        take_a = 1'b0;
        take_b = 1'b0;
        wait_ready("ab", 1, 3);
        pop_mon("ab_mon");
        check("ab_error", 32'(monitor_error), 32'd1);
        cpu_read("ab_r20", 8'h20, 32'h12345678);

        // CPU read and write together perform only the write.
        address = 8'h30;
        writedata = 32'h55AA55AA;
        read = 1'b1;
        write = 1'b1;
        #1;
        check("rw_waitreq", 32'(waitrequest), 32'd0);
        @(negedge clk);
        read = 1'b0;
        write = 1'b0;
        #1;
        check("rw_readdata_hold", readdata, 32'h12345678);
        cpu_read("rw_r30", 8'h30, 32'h55AA55AA);

`ifdef RECONFIG_CPU_OCIMEM_WRITE_PROTECT_EN
        jtag_a(8'hC0, 1'b0);
        jtag_b(32'h1);
        wait_ready("wp_b", 1, 2);
        check("wp_error", 32'(monitor_error), 32'd1);
        cpu_write("wp_cpu", 8'hC0, 32'h2);
        jtag_a(8'hC0, 1'b1);
        wait_ready("wp_rd", 1, 3);
        check("wp_not_jtag", 32'(MonDReg == 32'h1), 32'd0);
        check("wp_not_cpu", 32'(MonDReg == 32'h2), 32'd0);
`endif

        // Reset asserted while the FSM is in JRD.
        jtag_a(8'h10, 1'b1);
        check("jrd_waitreq", 32'(waitrequest), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rjrd_mondreg", MonDReg, 32'd0);
        check("rjrd_ready", 32'(monitor_ready), 32'd0);
        check("rjrd_error", 32'(monitor_error), 32'd0);
        check("rjrd_readdata", readdata, 32'd0);
        check("rjrd_waitreq", 32'(waitrequest), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rjrd_abort_ready", 32'(monitor_ready), 32'd0);
        check("rjrd_abort_mon", MonDReg, 32'd0);

        // Reset asserted while a write is pending in JWR.
        jtag_a(8'h40, 1'b0);
        jtag_b(32'h99999999);
        reset_n = 1'b0;
        #1;
        check("rjwr_waitreq", 32'(waitrequest), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        cpu_read("rjwr_r40", 8'h40, 32'h40404040);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
